// File: rtl/ser_pkg.sv
// Shared definitions for the serial link: FSM encoding, synchronizer depth and idle line level.
// The serializer side uses the same package so both ends agree on the framing.
package ser_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } ser_state_e;

   localparam int   SYNC_STAGES = 2;
   localparam logic IDLE_LEVEL  = 1'b1;

   // Index counters need at least one bit even for single-bit words.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ser_bit_sync.sv
// Multi-flop synchronizer for the asynchronous serial input.
// Resets to the idle line level so a reset never looks like a start bit.
module ser_bit_sync
   import ser_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES
) (
   input  logic clk,
   input  logic nreset,
   input  logic din,
   output logic dout
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   assign sync_d[0] = din;
   for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
      assign sync_d[gi] = sync_q[gi-1];
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         sync_q <= {STAGES{IDLE_LEVEL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/ser_frame_receiver.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, stop bit, sampled at mid-bit.
// Delivers words on a valid/ready port and pulses frame_err / overrun.
module ser_frame_receiver
   import ser_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 8
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             sin,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             frame_err,
   output logic             overrun,
   output logic             busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = idx_width(WIDTH);
   localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_IDX    = IW'(WIDTH - 1);

   logic             s;
   ser_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;
   logic             busy_q, busy_d;
   logic             deliver;
   logic [WIDTH:0]   shift_ext;

   ser_bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .nreset (nreset),
      .din    (sin),
      .dout   (s)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      deliver     = 1'b0;
      frame_err_d = 1'b0;
      shift_ext   = {s, shift_q};

      case (state_q)
         IDLE: begin
            if (!s) begin
               state_d = START;
               cnt_d   = HALF_RELOAD;
            end
         end
         START: begin
            if (cnt_q == '0) begin
               // A start bit that is high again at mid-bit was only a glitch.
               if (!s) begin
                  state_d = DATA;
                  cnt_d   = FULL_RELOAD;
                  idx_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DATA: begin
            if (cnt_q == '0) begin
               shift_d = shift_ext[WIDTH:1];
               cnt_d   = FULL_RELOAD;
               if (idx_q == LAST_IDX) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         STOP: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               if (s) begin
                  deliver = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      overrun_d    = 1'b0;
      // A word landing while the old one is accepted on the same edge replaces it cleanly.
      if (deliver) begin
         if (!dout_valid_q || dout_ready) begin
            dout_d       = shift_q;
            dout_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (dout_valid_q && dout_ready) begin
         dout_valid_d = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
         busy_q       <= busy_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_ser_frame_receiver.sv
// Bench for ser_frame_receiver: frame table plus hand-written corner sequences,
// with a word scoreboard popped on every valid/ready handshake.
module tb_ser_frame_receiver;

   localparam int W   = 8;
   localparam int CPB = 8;

   logic         clk = 1'b0;
   logic         nreset;
   logic         sin;
   logic [W-1:0] dout;
   logic         dout_valid;
   logic         dout_ready;
   logic         frame_err;
   logic         overrun;
   logic         busy;

   ser_frame_receiver #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .nreset     (nreset),
      .sin        (sin),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] data;
      logic         stop;
      int           exp_fe;
      int           exp_vcyc;
   } vec_t;

   vec_t         vecs[4];
   logic [W-1:0] exp_q[$];
   int           errors = 0;
   int           checks = 0;
   int           fe_cnt = 0;
   int           ov_cnt = 0;
   int           vcyc   = 0;
   int           bcyc   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic clear_counts();
      fe_cnt = 0;
      ov_cnt = 0;
      vcyc   = 0;
      bcyc   = 0;
   endtask

   task automatic send_bit(input logic b);
      sin = b;
      repeat (CPB) @(negedge clk);
   endtask

   // Called on a negedge; returns on the negedge right after the stop bit.
   task automatic send_frame(input logic [W-1:0] data, input logic stop, input logic ready_at_stop);
      $display("frame data=%02h stop=%0b ready_at_stop=%0b", data, stop, ready_at_stop);
      send_bit(1'b0);
      for (int i = 0; i < W; i++) send_bit(data[i]);
      sin = stop;
      repeat (CPB - 2) @(negedge clk);
      if (ready_at_stop) dout_ready = 1'b1;
      repeat (2) @(negedge clk);
      sin = 1'b1;
   endtask

   // Monitor samples just after the falling edge, when inputs and outputs are both settled.
   always @(negedge clk) begin
      #1;
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (dout_valid === 1'b1) vcyc++;
      if (busy === 1'b1) bcyc++;
      if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL handshake: got word %02h, required none", dout);
         end else begin
            logic [W-1:0] exp_w;
            exp_w = exp_q.pop_front();
            $display("accept dout=%02h required=%02h", dout, exp_w);
            if (dout !== exp_w) begin
               errors++;
               $display("FAIL handshake_word: got %02h, required %02h", dout, exp_w);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_fe: 0, exp_vcyc: 1};
      vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_fe: 1, exp_vcyc: 0};
      vecs[2] = '{data: 8'h00, stop: 1'b1, exp_fe: 0, exp_vcyc: 1};
      vecs[3] = '{data: 8'hFF, stop: 1'b1, exp_fe: 0, exp_vcyc: 1};

      nreset     = 1'b0;
      sin        = 1'b1;
      dout_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_dout", 32'(dout), 32'h0);
      check("reset_valid", 32'(dout_valid), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_fe", 32'(frame_err), 32'h0);
      check("reset_ov", 32'(overrun), 32'h0);
      nreset = 1'b1;
      repeat (4) @(negedge clk);
      check("idle_busy", 32'(busy), 32'h0);

      // Table: single frames with the consumer always ready.
      dout_ready = 1'b1;
      for (int v = 0; v < 4; v++) begin
         clear_counts();
         if (vecs[v].stop) exp_q.push_back(vecs[v].data);
         send_frame(vecs[v].data, vecs[v].stop, 1'b0);
         repeat (8) @(negedge clk);
         check($sformatf("vec%0d_frame_err", v), 32'(fe_cnt), 32'(vecs[v].exp_fe));
         check($sformatf("vec%0d_valid_cycles", v), 32'(vcyc), 32'(vecs[v].exp_vcyc));
         check($sformatf("vec%0d_overrun", v), 32'(ov_cnt), 32'h0);
         check($sformatf("vec%0d_busy", v), 32'(busy), 32'h0);
      end

      // Two-cycle low glitch: START runs for its half bit then aborts.
      clear_counts();
      $display("glitch 2 cycles low");
      sin = 1'b0;
      repeat (2) @(negedge clk);
      sin = 1'b1;
      repeat (10) @(negedge clk);
      check("glitch_busy_cycles", 32'(bcyc), 32'd4);
      check("glitch_valid", 32'(vcyc), 32'h0);
      check("glitch_fe", 32'(fe_cnt), 32'h0);
      check("glitch_busy", 32'(busy), 32'h0);

      // Overrun: consumer stalled across two frames, second word dropped.
      clear_counts();
      dout_ready = 1'b0;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, 1'b0);
      repeat (8) @(negedge clk);
      send_frame(8'h22, 1'b1, 1'b0);
      repeat (8) @(negedge clk);
      check("ovr_count", 32'(ov_cnt), 32'd1);
      check("ovr_dout_held", 32'(dout), 32'h11);
      check("ovr_valid_held", 32'(dout_valid), 32'h1);
      check("ovr_fe", 32'(fe_cnt), 32'h0);
      dout_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("ovr_valid_drop", 32'(dout_valid), 32'h0);
      check("ovr_dout_keep", 32'(dout), 32'h11);

      // Back-to-back frames; ready arrives on the second stop-sample edge.
      clear_counts();
      dout_ready = 1'b0;
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h80);
      send_frame(8'h01, 1'b1, 1'b0);
      send_frame(8'h80, 1'b1, 1'b1);
      repeat (8) @(negedge clk);
      check("b2b_overrun", 32'(ov_cnt), 32'h0);
      check("b2b_dout", 32'(dout), 32'h80);
      check("b2b_valid_drop", 32'(dout_valid), 32'h0);

      // Asynchronous reset in the middle of a data phase.
      clear_counts();
      $display("frame data=ff aborted by reset");
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      check("pre_rst_busy", 32'(busy), 32'h1);
      #2;
      nreset = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_dout", 32'(dout), 32'h0);
      check("rst_valid", 32'(dout_valid), 32'h0);
      check("rst_fe", 32'(frame_err), 32'h0);
      sin = 1'b1;
      repeat (4) @(negedge clk);
      nreset = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'h0);
      clear_counts();
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1, 1'b0);
      repeat (8) @(negedge clk);
      check("post_rst_dout", 32'(dout), 32'h5A);
      check("post_rst_valid_cycles", 32'(vcyc), 32'd1);
      check("post_rst_fe", 32'(fe_cnt), 32'h0);

      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
